// File: rtl/snn_pkg.sv
// Shared types and constants for the spike output path of a neuromorphic core.
package snn_pkg;

  // Tick-level control states of the spike output encoder.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_e;

  // Default core geometry: 256 neurons per core, 1-bit core identifier.
  localparam int DEF_NUM_NEURONS   = 256;
  localparam int DEF_CORE_ID_WIDTH = 1;
  localparam int DEF_NIDX_W        = $clog2(DEF_NUM_NEURONS);
  localparam int DEF_PKT_W         = DEF_CORE_ID_WIDTH + DEF_NIDX_W;

  // Router packet for the default geometry: core identifier in the MSBs,
  // neuron index below it. Encoder instances with other geometries use a
  // parameterised struct with this same field order.
  typedef struct packed {
    logic [DEF_CORE_ID_WIDTH-1:0] core_id;
    logic [DEF_NIDX_W-1:0]        neuron_idx;
  } pkt_t;

  // Width of an up-counter that must be able to hold the value n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spike_fifo.sv
// Synchronous show-ahead FIFO: the head entry is visible on rdata_o whenever
// empty_o is low. Pushes while full and pops while empty are ignored.
module spike_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer update; reset empties the FIFO.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Storage write.
  // NOTE: the storage array has no reset; the pointers alone define validity,
  // and leaving the array unreset lets it map onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/spike_out_encoder.sv
// Collects one neuron result per handshake during a tick, buffers the
// indices of spiking neurons and emits them as {CORE_ID, neuron index}
// router packets. Signals tick completion once all neurons are reported and
// the buffer has drained.
module spike_out_encoder
  import snn_pkg::*;
#(
  parameter int                     NUM_NEURONS   = 256,
  parameter int                     FIFO_DEPTH    = 16,
  parameter int                     CORE_ID_WIDTH = 1,
  parameter logic [CORE_ID_WIDTH-1:0] CORE_ID     = '0,
  localparam int                    NIDX_W        = $clog2(NUM_NEURONS),
  localparam int                    PKT_W         = CORE_ID_WIDTH + NIDX_W,
  localparam int                    CNT_W         = count_width(NUM_NEURONS)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              tick_i,
  input  logic              neuron_valid_i,
  input  logic              spike_i,
  input  logic [NIDX_W-1:0] neuron_idx_i,
  output logic              in_ready_o,
  output logic              pkt_valid_o,
  input  logic              pkt_ready_i,
  output logic [PKT_W-1:0]  pkt_data_o,
  output logic              busy_o,
  output logic              tick_done_o,
  output logic [CNT_W-1:0]  spike_count_o,
  output logic              err_o
);

  typedef struct packed {
    logic [CORE_ID_WIDTH-1:0] core_id;
    logic [NIDX_W-1:0]        neuron_idx;
  } pkt_s;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_NEURONS - 1);

  state_e            state_q;
  logic [CNT_W-1:0]  nrn_cnt_q;
  logic [CNT_W-1:0]  spike_cnt_q;
  logic              err_q;

  logic              fifo_full, fifo_empty;
  logic [NIDX_W-1:0] fifo_head;
  logic              accept, push, pop;
  pkt_s              pkt;

  // Handshakes. in_ready_o depends only on registered state, so a full
  // buffer stalls every result, spiking or not.
  assign in_ready_o  = (state_q == COLLECT) && !fifo_full;
  assign accept      = neuron_valid_i && in_ready_o;
  assign push        = accept && spike_i;
  assign pkt_valid_o = !fifo_empty;
  assign pop         = pkt_valid_o && pkt_ready_i;

  assign busy_o        = (state_q != IDLE);
  assign tick_done_o   = (state_q == DONE);
  assign spike_count_o = spike_cnt_q;
  assign err_o         = err_q;

  spike_fifo #(
    .WIDTH (NIDX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push),
    .wdata_i (neuron_idx_i),
    .pop_i   (pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Packet assembly; the index field reads as zero while nothing is buffered
  // so the port shows a defined value even though the storage is unreset.
  // NOTE: every always_comb output gets a value on every path (here
  // unconditionally) so no latch is inferred.
  always_comb begin
    pkt.core_id    = CORE_ID;
    pkt.neuron_idx = fifo_empty ? '0 : fifo_head;
  end
  assign pkt_data_o = pkt;

  // Tick FSM with neuron and spike counters.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      nrn_cnt_q   <= '0;
      spike_cnt_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick_i) begin
            state_q     <= COLLECT;
            nrn_cnt_q   <= '0;
            spike_cnt_q <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            nrn_cnt_q <= nrn_cnt_q + CNT_W'(1);
            if (spike_i) spike_cnt_q <= spike_cnt_q + CNT_W'(1);
            if (nrn_cnt_q == LAST_CNT) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (fifo_empty) state_q <= DONE;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Sticky protocol error: results offered outside COLLECT, or a tick
  // request while a tick is still in flight.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else if ((neuron_valid_i && (state_q != COLLECT)) ||
                 (tick_i && (state_q != IDLE))) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: doc/spike_out_encoder.md
# spike_out_encoder

Output side of a neuromorphic core. During a tick, the neuron update loop hands over one neuron result per handshake: a spike bit and a neuron index. This block buffers the spiking indices in a FIFO and emits them to the core's router port as packets of the form {CORE_ID, neuron index}. Once every neuron has been reported and the buffer has drained, it signals completion of the tick back to the core scheduler.

## Interface
- NUM_NEURONS, 256: neurons evaluated per tick. Power of two.
- FIFO_DEPTH, 16: spike buffer entries. Power of two, ≥2.
- CORE_ID_WIDTH, 1: width of the core identifier field.
- CORE_ID, 0: constant placed in the packet MSBs.
- Derived: NIDX_W = $clog2(NUM_NEURONS); PKT_W = CORE_ID_WIDTH + NIDX_W; CNT_W = $clog2(NUM_NEURONS+1).

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- tick_i  in  1  one-cycle pulse that starts a tick.
- neuron_valid_i  in  1  neuron result valid.
- spike_i  in  1  that neuron fired (the neuron block's spike_o).
- neuron_idx_i  in  NIDX_W  index of the reported neuron.
- in_ready_o  out  1  result accepted when high together with neuron_valid_i.
- pkt_valid_o  out  1  packet available.
- pkt_ready_i  in  1  router accepts the packet.
- pkt_data_o  out  PKT_W  {CORE_ID, neuron_idx}.
- busy_o  out  1  state ≠ IDLE.
- tick_done_o  out  1  one-cycle completion pulse.
- spike_count_o  out  CNT_W  spikes accepted in the current/last tick. Holds until the next tick_i.
- err_o  out  1  sticky protocol error. Cleared only by reset.

## Operation
- FSM states and transitions:
  - IDLE: on tick_i → COLLECT. Clear the accepted-neuron counter and spike_count_o.
  - COLLECT:
    - in_ready_o = !fifo_full.
    - Each accept increments the neuron counter.
    - An accept with spike_i=1 pushes neuron_idx_i and increments spike_count_o.
    - An accept that brings the counter to NUM_NEURONS → DRAIN.
  - DRAIN: fifo_empty → DONE.
  - DONE: tick_done_o=1 → IDLE.
- in_ready_o is 0 outside COLLECT.
- Full FIFO:
  - in_ready_o drops even for non-spiking results.
  - No push while full, even if a pop happens in the same cycle.
- Output port:
  - pkt_valid_o = !fifo_empty.
  - pkt_data_o = {CORE_ID, head entry}.
  - Pop on pkt_valid_o && pkt_ready_i.
  - Packet order equals acceptance order.
- neuron_idx_i is not checked for order or duplicates; only accepts are counted.
- Packet popping is independent of FSM state, so DRAIN proceeds under any pkt_ready_i pattern.
- err_o is set by either:
  - neuron_valid_i=1 outside COLLECT (the result is dropped); or
  - tick_i while busy_o=1 (the pulse is ignored).
- Counters: the neuron counter is CNT_W wide and never wraps, because exit happens at NUM_NEURONS. spike_count_o saturates at NUM_NEURONS by construction.
- Reset (any cycle, including mid-tick): FSM→IDLE and FIFO emptied; the in-flight tick is abandoned with no tick_done_o.

## Timing
- Reset values: in_ready_o=0, pkt_valid_o=0, pkt_data_o={CORE_ID,0}, busy_o=0, tick_done_o=0, spike_count_o=0, err_o=0.
- tick_i at cycle t → busy_o and in_ready_o high at t+1 (if not full).
- Spike accepted at t, FIFO previously empty → pkt_valid_o high at t+1 with that index.
- Last neuron accepted at t → DRAIN at t+1. With the FIFO empty at t+1, tick_done_o=1 at t+2 and busy_o=0 at t+3. Minimum tick_done_o latency is 2 cycles after the last accept.
- Throughput: one accept per cycle and one pop per cycle, concurrently when the FIFO is neither full nor empty.
- tick_done_o, busy_o, in_ready_o and pkt_valid_o are decoded from registers only. There is no combinational path from any input to any output.

## Structure
- Shared package snn_pkg holds:
  - the state enum (IDLE, COLLECT, DRAIN, DONE);
  - the packet struct {core_id, neuron_idx};
  - width helper constants.
- Sub-module spike_fifo: synchronous show-ahead FIFO, parameters WIDTH and DEPTH, outputs full/empty, async active-low reset on the pointers. The FSM and counters stay in spike_out_encoder.

## Test plan
- Bench parameters NUM_NEURONS=8, FIFO_DEPTH=4, CORE_ID=1:
  - tick, spikes on neurons 1, 4, 7, pkt_ready_i=1 → packets 0x9, 0xC, 0xF in order; spike_count_o=3; tick_done_o is a single pulse 2 cycles after the neuron-7 accept.
  - tick, no spikes → no pkt_valid_o; tick_done_o at accept(7)+2; spike_count_o=0.
  - tick, all 8 spike, pkt_ready_i=0 → in_ready_o low after 4 accepts. Releasing pkt_ready_i resumes accepts. All 8 packets arrive in order; tick_done_o follows the final pop.
  - Random pkt_ready_i backpressure during DRAIN → no packet lost or duplicated; tick_done_o only after FIFO empty.
  - neuron_valid_i in IDLE, plus tick_i during COLLECT → err_o=1 sticky; the tick still completes normally.
  - Reset asserted mid-COLLECT with 2 entries buffered → all outputs at reset values immediately; no tick_done_o; the next tick behaves as fresh.
